// File: rtl/rr_arb4_onehot_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb4_onehot_pkg
//  Description : Shared constants and the state type for the 4-way
//                round-robin one-hot arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package rr_arb4_onehot_pkg;

    localparam int NUM_REQ = 4;
    localparam int PTR_W   = 2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

endpackage : rr_arb4_onehot_pkg
`default_nettype wire

// File: rtl/rr_arb4_onehot_pick4.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick4
//  Description : Combinational rotating-priority picker. It searches req
//                starting at ptr and wrapping mod 4. It returns the winner as
//                a one-hot vector plus its index. All-zero req gives
//                onehot = 0 and idx = 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick4
    import rr_arb4_onehot_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [PTR_W-1:0]   idx
);

    logic             w_found;
    logic [PTR_W-1:0] w_cand;

    // Walk ptr, ptr+1, ... (2-bit arithmetic wraps naturally) and keep the first hit.
    always_comb begin
        onehot  = '0;
        idx     = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = ptr + PTR_W'(k);
            if (!w_found && req[w_cand]) begin
                w_found        = 1'b1;
                onehot[w_cand] = 1'b1;
                idx            = w_cand;
            end
        end
    end

endmodule : rr_pick4
`default_nettype wire

// File: rtl/rr_arb4_onehot.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb4_onehot
//  Description : Registered 4-way round-robin arbiter. It produces a grant
//                vector that is always one-hot or all-zero, so the encoder
//                downstream never sees an illegal input. A grant is held
//                until done, until the owner drops its request, or until the
//                optional hold timeout fires. Every release is followed by at
//                least one all-zero cycle.
//  Options     : `define ARB_TIMEOUT_EN enables the hold counter and the
//                timeout output. MAX_HOLD = 0 means no limit.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb4_onehot
    import rr_arb4_onehot_pkg::*;
#(
    parameter int MAX_HOLD = 15,
    parameter int CNT_W    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid
`ifdef ARB_TIMEOUT_EN
    ,
    output logic               timeout
`endif
);

    state_e             state_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [NUM_REQ-1:0] grant_q;
    logic               grant_valid_q;

    logic [NUM_REQ-1:0] w_pick_onehot;
    logic [PTR_W-1:0]   w_pick_idx;
    logic               w_owner_req;
    logic               w_user_release;
    logic               w_hold_expired;

    rr_pick4 u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .onehot (w_pick_onehot),
        .idx    (w_pick_idx)
    );

    // The owner keeps the grant only while its own request bit stays high.
    assign w_owner_req    = |(req & grant_q);
    assign w_user_release = done | ~w_owner_req;

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q;
    logic             timeout_q;

    // The counter reads MAX_HOLD-1 in the last allowed cycle, so the grant
    // is visible for exactly MAX_HOLD cycles.
    assign w_hold_expired = (MAX_HOLD != 0) && (cnt_q == CNT_W'(MAX_HOLD - 1));
    assign timeout        = timeout_q;
`else
    logic w_unused_cfg;
    assign w_unused_cfg   = (MAX_HOLD != 0) ^ (CNT_W != 0);
    assign w_hold_expired = 1'b0;
`endif

    // Arbitration FSM with pointer, hold counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_q         <= '0;
            timeout_q     <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            if (state_q == ST_IDLE) begin
                // done is ignored here; only a non-zero req starts a grant.
                if (|req) begin
                    state_q       <= ST_BUSY;
                    grant_q       <= w_pick_onehot;
                    grant_valid_q <= |w_pick_onehot;
                    ptr_q         <= w_pick_idx + PTR_W'(1);
`ifdef ARB_TIMEOUT_EN
                    cnt_q         <= '0;
`endif
                end
            end else begin
                if (w_user_release || w_hold_expired) begin
                    // Drop to all-zero first. The next owner is picked in IDLE.
                    state_q       <= ST_IDLE;
                    grant_q       <= '0;
                    grant_valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
                    // An ordinary release takes precedence over a timeout.
                    timeout_q     <= ~w_user_release;
`endif
                end else begin
`ifdef ARB_TIMEOUT_EN
                    cnt_q         <= cnt_q + CNT_W'(1);
`endif
                end
            end
        end
    end

    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;

endmodule : rr_arb4_onehot
`default_nettype wire

// File: tb/tb_rr_arb4_onehot.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_arb4_onehot
//  Description : Directed self-checking bench for rr_arb4_onehot.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arb4_onehot;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic       grant_valid;
    logic       timeout;

    int total;
    int bad;

    rr_arb4_onehot #(
        .MAX_HOLD (4),
        .CNT_W    (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_valid (grant_valid)
`ifdef ARB_TIMEOUT_EN
        ,
        .timeout     (timeout)
`endif
    );

`ifndef ARB_TIMEOUT_EN
    initial timeout = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of the downstream 4-to-2 encoder.
    function automatic logic [1:0] enc(input logic [3:0] g);
        case (g)
            4'b0010: enc = 2'd1;
            4'b0100: enc = 2'd2;
            4'b1000: enc = 2'd3;
            default: enc = 2'd0;
        endcase
    endfunction

    // Advance one clock and settle 1 time unit past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b1111;
        done  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (grant !== 4'b0000) begin
            bad++;
            $display("FAIL reset_grant: got %b want 0000", grant);
        end
        total++;
        if (grant_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid: got %b want 0", grant_valid);
        end
`ifdef ARB_TIMEOUT_EN
        total++;
        if (timeout !== 1'b0) begin
            bad++;
            $display("FAIL reset_timeout: got %b want 0", timeout);
        end
`endif
        req   = 4'b0000;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        do_reset();
        // done while idle must be ignored
        done = 1'b1;
        step();
        done = 1'b0;
        total++;
        if (grant !== 4'b0000) begin
            bad++;
            $display("FAIL idle_done: got %b want 0000", grant);
        end
        req = 4'b0101;
        step();
        total++;
        if (grant !== 4'b0001 || grant_valid !== 1'b1) begin
            bad++;
            $display("FAIL basic_first: got %b/%b want 0001/1", grant, grant_valid);
        end
        done = 1'b1;
        step();
        done = 1'b0;
        total++;
        if (grant !== 4'b0000 || grant_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_gap: got %b/%b want 0000/0", grant, grant_valid);
        end
        step();
        total++;
        if (grant !== 4'b0100) begin
            bad++;
            $display("FAIL basic_second: got %b want 0100", grant);
        end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_seq [5];
        exp_seq[0] = 4'b0001;
        exp_seq[1] = 4'b0010;
        exp_seq[2] = 4'b0100;
        exp_seq[3] = 4'b1000;
        exp_seq[4] = 4'b0001;
        do_reset();
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            step();
            total++;
            if (grant !== exp_seq[n]) begin
                bad++;
                $display("FAIL rot_grant[%0d]: got %b want %b", n, grant, exp_seq[n]);
            end
            step();
            total++;
            if (grant !== exp_seq[n]) begin
                bad++;
                $display("FAIL rot_hold[%0d]: got %b want %b", n, grant, exp_seq[n]);
            end
            done = 1'b1;
            step();
            done = 1'b0;
            total++;
            if (grant !== 4'b0000) begin
                bad++;
                $display("FAIL rot_gap[%0d]: got %b want 0000", n, grant);
            end
        end
    endtask

    task automatic test_req_drop();
        do_reset();
        req = 4'b0100;
        step();
        total++;
        if (grant !== 4'b0100 || enc(grant) !== 2'd2) begin
            bad++;
            $display("FAIL drop_owner2: got %b enc %0d want 0100 enc 2", grant, enc(grant));
        end
        // other requesters appearing must not disturb the current grant
        req = 4'b1111;
        step();
        total++;
        if (grant !== 4'b0100) begin
            bad++;
            $display("FAIL drop_stable: got %b want 0100", grant);
        end
        req = 4'b1001;
        step();
        total++;
        if (grant !== 4'b0000) begin
            bad++;
            $display("FAIL drop_gap: got %b want 0000", grant);
        end
        step();
        total++;
        if (grant !== 4'b1000 || enc(grant) !== 2'd3) begin
            bad++;
            $display("FAIL drop_next: got %b enc %0d want 1000 enc 3", grant, enc(grant));
        end
        // done together with the owner dropping is one release; ptr wrapped to 0
        req  = 4'b0001;
        done = 1'b1;
        step();
        done = 1'b0;
        total++;
        if (grant !== 4'b0000) begin
            bad++;
            $display("FAIL dual_release: got %b want 0000", grant);
        end
        step();
        total++;
        if (grant !== 4'b0001) begin
            bad++;
            $display("FAIL wrap_grant: got %b want 0001", grant);
        end
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        req = 4'b0010;
        for (int n = 0; n < 4; n++) begin
            step();
            total++;
            if (grant !== 4'b0010 || timeout !== 1'b0) begin
                bad++;
                $display("FAIL to_hold[%0d]: got %b/%b want 0010/0", n, grant, timeout);
            end
        end
        step();
        total++;
        if (grant !== 4'b0000 || timeout !== 1'b1) begin
            bad++;
            $display("FAIL to_fire: got %b/%b want 0000/1", grant, timeout);
        end
        step();
        total++;
        if (grant !== 4'b0010 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL to_regrant: got %b/%b want 0010/0", grant, timeout);
        end
    endtask

    task automatic test_timeout_done();
        do_reset();
        req = 4'b0010;
        repeat (4) step();
        done = 1'b1;
        step();
        done = 1'b0;
        total++;
        if (grant !== 4'b0000 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL to_done: got %b/%b want 0000/0", grant, timeout);
        end
    endtask
`else
    task automatic test_no_timeout();
        do_reset();
        req = 4'b0010;
        repeat (20) step();
        total++;
        if (grant !== 4'b0010) begin
            bad++;
            $display("FAIL long_hold: got %b want 0010", grant);
        end
    endtask
`endif

    task automatic test_async_reset();
        do_reset();
        req = 4'b1000;
        step();
        total++;
        if (grant !== 4'b1000) begin
            bad++;
            $display("FAIL ar_owner3: got %b want 1000", grant);
        end
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (grant !== 4'b0000 || grant_valid !== 1'b0) begin
            bad++;
            $display("FAIL ar_clear: got %b/%b want 0000/0", grant, grant_valid);
        end
        req = 4'b1111;
        #1;
        rst_n = 1'b1;
        step();
        total++;
        if (grant !== 4'b0001) begin
            bad++;
            $display("FAIL ar_ptr0: got %b want 0001", grant);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        test_reset();
        test_basic();
        test_rotation();
        test_req_drop();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
        test_timeout_done();
`else
        test_no_timeout();
`endif
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_rr_arb4_onehot
`default_nettype wire

// File: doc/rr_arb4_onehot.md
Name: rr_arb4_onehot

Overview:
- Registered 4-way round-robin arbiter that sits directly upstream of the 4-to-2 encoder.
- Converts an arbitrary 4-bit request vector into a guaranteed one-hot (or all-zero) grant vector, so the encoder input is always legal.
- Holds each grant until the owner releases, drops its request, or (optionally) times out.
- Rotating priority ensures no requester starves.

Parameters:
- MAX_HOLD, 15, maximum cycles a grant may be held before forced release. Used only when ARB_TIMEOUT_EN is defined. 0 = no limit.
- CNT_W, 4, hold-counter width. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  request vector; bit i = requester i. Any number of bits may be set.
- done  input  1  single-cycle pulse from the current owner, releasing the grant.
- grant  output  4  registered grant, always one-hot or 4'b0000; feeds the encoder `in`.
- grant_valid  output  1  high whenever grant != 0.
- timeout  output  1  single-cycle pulse on forced release. Present only when ARB_TIMEOUT_EN is defined.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n). Asserting rst_n low clears all state immediately, independent of clk.
- Reset values: grant=0000, grant_valid=0, timeout=0, state=IDLE, priority pointer ptr=0 (requester 0 highest), hold counter=0.
- States:
  - IDLE: grant=0000.
  - BUSY: grant holds exactly one bit.
- IDLE -> BUSY:
  - Condition: on a clk edge where req != 0.
  - Winner: the first set bit searching ptr, ptr+1, ... mod 4.
  - Latency: grant is registered and visible 1 cycle after req is sampled.
  - On the same edge: ptr <= winner+1 mod 4; hold counter <= 0.
- BUSY -> IDLE (release): on the first edge where any of the following is true:
  - (a) done=1;
  - (b) req[owner]=0;
  - (c) the timeout condition below.
  - On release, grant <= 0000 for at least one cycle (mandatory gap). No back-to-back grant switch, so the encoder never sees a transient two-hot value.
- Staying in BUSY: grant is stable and unaffected by changes to other req bits.
- done while IDLE: ignored.
- Simultaneous release conditions: done together with a dropped req is a single release. done together with a timeout is a normal release and timeout stays 0; done has priority.
- Wrap-around: ptr is 2 bits and wraps 3 -> 0.
- Fairness: with all four requesters continuously active, grants rotate 0,1,2,3,0,...
- Reset mid-grant: grant clears asynchronously and ptr returns to 0.
- Outputs: all are driven from flops, with no combinational path from req to grant. grant_valid is the registered OR of the next grant.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - Hold counter increments every BUSY cycle.
  - When the counter reaches MAX_HOLD-1 (and MAX_HOLD != 0), the next edge forces release and timeout pulses high for exactly one cycle, aligned with grant going to 0000.
  - The timed-out owner loses priority normally, via the ptr already advanced.
- Undefined: no counter, no timeout port, MAX_HOLD is ignored; grants last until done or req drop.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=1'b0, ST_BUSY=1'b1;
  - NUM_REQ=4;
  - PTR_W=2.
- One natural sub-module, rr_pick4: combinational rotating-priority picker with inputs req[3:0] and ptr[1:0], outputs onehot[3:0] and idx[1:0].
- The FSM, pointer and counter live in the top module.

Test Plan:
- Reset then req=0101, ptr=0: grant=0001 one cycle later. After done: grant=0000 for 1 cycle, then grant=0100.
- req=1111 held, done pulsed every 3rd cycle: grant sequence 0001, 0010, 0100, 1000, 0001, with a 0000 cycle between each.
- Owner 2 granted, req[2] drops while req=1001: grant->0000 next edge, then grant=1000 (ptr=3). Check the encoder output sequence 10, then 11.
- ARB_TIMEOUT_EN, MAX_HOLD=4, req=0010 held, no done: grant=0010 for exactly 4 cycles, then timeout=1 for 1 cycle with grant=0000, then re-grant 0010.
- Timeout and done in the same cycle: timeout stays 0; ordinary release.
- rst_n low mid-grant (grant=1000): grant=0000 asynchronously, before the next clk edge. After release with req=1111: grant=0001.
